header_checker: RTL



---
 rtl/header_pkg.sv | 19 +
 rtl/hdr_chk_out_stage.sv | 40 ++++
 rtl/header_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/header_pkg.sv
// Shared definitions for the framed-stream header adder/checker pair:
// header magic, header field positions and the checker FSM encoding.
package header_pkg;

    // Constant carried in the magic field of every valid header beat
    localparam logic [31:0] HDR_MAGIC = 32'hC0DE_0001;

    // Header field positions (identical on the adder side)
    localparam int unsigned SEQ_LSB   = 0;
    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned MAGIC_LSB = 32;
    localparam int unsigned MAGIC_W   = 32;

    // Checker FSM encoding
    localparam logic [1:0] ST_HDR     = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

endpackage

// File: rtl/hdr_chk_out_stage.sv
// Single-entry registered output stage of the header checker.
// Holds one payload beat; accepts a new beat whenever it is empty or
// its current beat is being taken downstream in the same cycle.
module hdr_chk_out_stage #(
    parameter int unsigned DW = 512
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic [DW-1:0]   in_data,
    input  logic [DW/8-1:0] in_keep,
    input  logic            in_last,
    output logic            can_load,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [DW/8-1:0] out_keep,
    output logic            out_last
);

    assign can_load = !out_valid || out_ready;

    // Load a new beat, or drain the held one; otherwise hold stable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/header_checker.sv
// header_checker: validates and strips the one-beat counter header from
// each framed AXI-Stream packet and forwards the payload unchanged.
// Sequence gaps and bad magic values are flagged with one-cycle pulses.
// Build option: define HDR_CHK_STATS_EN to implement the saturating
// statistics counters; otherwise the counter ports are tied to zero.
module header_checker
    import header_pkg::*;
#(
    parameter int unsigned DW    = 512,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DW-1:0]    AXIS_IN_TDATA,
    input  logic             AXIS_IN_TVALID,
    output logic             AXIS_IN_TREADY,
    input  logic [DW/8-1:0]  AXIS_IN_TKEEP,
    input  logic             AXIS_IN_TLAST,
    output logic [DW-1:0]    AXIS_OUT_TDATA,
    output logic             AXIS_OUT_TVALID,
    input  logic             AXIS_OUT_TREADY,
    output logic [DW/8-1:0]  AXIS_OUT_TKEEP,
    output logic             AXIS_OUT_TLAST,
    output logic             seq_err,
    output logic             magic_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] seq_err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [1:0]  state;
    logic [31:0] exp_seq;
    logic        stage_ready;
    logic        in_fire;
    logic        hdr_fire;
    logic [31:0] rx_seq;
    logic [31:0] rx_magic;
    logic        magic_ok;
    logic        bad_magic_ev;
    logic        seq_mis_ev;

    assign rx_seq   = AXIS_IN_TDATA[SEQ_LSB +: SEQ_W];
    assign rx_magic = AXIS_IN_TDATA[MAGIC_LSB +: MAGIC_W];
    assign magic_ok = (rx_magic == HDR_MAGIC);

    // Payload beats are gated by the output stage; header/drop beats never stall
    assign AXIS_IN_TREADY = (state == ST_PAYLOAD) ? stage_ready : 1'b1;
    assign in_fire        = AXIS_IN_TVALID && AXIS_IN_TREADY;
    assign hdr_fire       = in_fire && (state == ST_HDR);

    assign bad_magic_ev = hdr_fire && !magic_ok;
    assign seq_mis_ev   = hdr_fire && magic_ok && !AXIS_IN_TLAST && (rx_seq != exp_seq);

    hdr_chk_out_stage #(
        .DW(DW)
    ) u_out_stage (
        .clk       (clk),
        .resetn    (resetn),
        .load      (in_fire && (state == ST_PAYLOAD)),
        .in_data   (AXIS_IN_TDATA),
        .in_keep   (AXIS_IN_TKEEP),
        .in_last   (AXIS_IN_TLAST),
        .can_load  (stage_ready),
        .out_ready (AXIS_OUT_TREADY),
        .out_valid (AXIS_OUT_TVALID),
        .out_data  (AXIS_OUT_TDATA),
        .out_keep  (AXIS_OUT_TKEEP),
        .out_last  (AXIS_OUT_TLAST)
    );

    // Packet framing FSM and expected-sequence tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_HDR;
            exp_seq <= '0;
        end else if (in_fire) begin
            case (state)
                ST_HDR: begin
                    if (!magic_ok) begin
                        state <= AXIS_IN_TLAST ? ST_HDR : ST_DROP;
                    end else if (!AXIS_IN_TLAST) begin
                        // Resynchronise to the received number, gap or not
                        exp_seq <= rx_seq + 32'd1;
                        state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (AXIS_IN_TLAST) state <= ST_HDR;
                ST_DROP:    if (AXIS_IN_TLAST) state <= ST_HDR;
                default:    state <= ST_HDR;
            endcase
        end
    end

    // Error pulses, high for the single cycle after the offending header
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_err   <= 1'b0;
            magic_err <= 1'b0;
        end else begin
            seq_err   <= seq_mis_ev;
            magic_err <= bad_magic_ev;
        end
    end

`ifdef HDR_CHK_STATS_EN
    logic             runt_ev;
    logic             good_ev;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] seq_err_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    assign runt_ev = hdr_fire && magic_ok && AXIS_IN_TLAST;
    assign good_ev = in_fire && (state == ST_PAYLOAD) && AXIS_IN_TLAST;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q     <= '0;
            seq_err_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (good_ev && (pkt_cnt_q != '1))
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (seq_mis_ev && (seq_err_cnt_q != '1))
                seq_err_cnt_q <= seq_err_cnt_q + 1'b1;
            if ((bad_magic_ev || runt_ev) && (drop_cnt_q != '1))
                drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign pkt_cnt     = pkt_cnt_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign drop_cnt    = drop_cnt_q;
`else
    assign pkt_cnt     = '0;
    assign seq_err_cnt = '0;
    assign drop_cnt    = '0;
`endif

endmodule
